// File: rtl/md_unit_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_defs (package)
//  Description : Shared definitions for the HI/LO multiply/divide unit:
//                MD operation codes, controller state encoding and the
//                helper that classifies ops which occupy the unit.
//  Revision    : 1.0  initial release
// ============================================================================
package md_defs;

  // MD operation codes as presented by EX and decoded by ID.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Controller state encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // One bit per op code; set for ops that start a multi-cycle computation
  // (MULT, MULTU, DIV, DIVU).
  localparam logic [15:0] c_busy_op_set = 16'b0000_0000_0001_1110;

  function automatic logic md_is_busy_op(input logic [3:0] op);
    return c_busy_op_set[op];
  endfunction

  function automatic logic md_is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_controller_if
//  Description : Bundle between the pipeline (EX/ID) and the MD controller.
//                master : pipeline side, drives op requests and ID decode.
//                slave  : MD controller, returns busy/stall and HI/LO data.
//  Signals     : start, op[3:0], rs[31:0], rt[31:0], id_md_use  (to unit)
//                busy, stall, hi[31:0], lo[31:0], read_data[31:0] (from unit)
//  Revision    : 1.0  initial release
// ============================================================================
interface md_unit_controller_if;

  logic        start;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        id_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] read_data;

  modport master (
    output start, op, rs, rt, id_md_use,
    input  busy, stall, hi, lo, read_data
  );

  modport slave (
    input  start, op, rs, rt, id_md_use,
    output busy, stall, hi, lo, read_data
  );

endinterface
`default_nettype wire

// File: rtl/md_unit_controller_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational HI/LO result generator for MD ops.
//                Returns the value HI/LO should take when the op commits;
//                ops that do not compute (and divide by zero) return the
//                current HI/LO unchanged.
//  Ports       : i_op[3:0], i_rs[31:0], i_rt[31:0], i_hi[31:0], i_lo[31:0]
//                o_res_hi[31:0], o_res_lo[31:0]
//  Revision    : 1.0  initial release
// ============================================================================
module md_arith
  import md_defs::*;
(
  input  wire logic [3:0]  i_op,
  input  wire logic [31:0] i_rs,
  input  wire logic [31:0] i_rt,
  input  wire logic [31:0] i_hi,
  input  wire logic [31:0] i_lo,
  output logic      [31:0] o_res_hi,
  output logic      [31:0] o_res_lo
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_is_sdiv;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;

  // Operands are explicitly widened so the low 64 bits are the exact product.
  assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // A single unsigned divider serves both divides. Signed divide works on
  // magnitudes and restores signs afterwards: quotient negative when the
  // operand signs differ, remainder follows the dividend. The magnitude of
  // 0x80000000 is 0x80000000 as an unsigned value, so 0x80000000 / -1 comes
  // out as quotient 0x80000000, remainder 0 without a special case.
  assign w_is_sdiv  = (i_op == MD_DIV);
  assign w_a_mag    = (w_is_sdiv && i_rs[31]) ? (32'd0 - i_rs) : i_rs;
  assign w_b_mag    = (w_is_sdiv && i_rt[31]) ? (32'd0 - i_rt) : i_rt;
  // Keep the divider well defined on rt==0; its result is discarded then.
  assign w_divisor  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_quot_mag = w_a_mag / w_divisor;
  assign w_rem_mag  = w_a_mag % w_divisor;
  assign w_quot_s   = (i_rs[31] ^ i_rt[31]) ? (32'd0 - w_quot_mag) : w_quot_mag;
  assign w_rem_s    = i_rs[31] ? (32'd0 - w_rem_mag) : w_rem_mag;

  always_comb begin
    o_res_hi = i_hi;
    o_res_lo = i_lo;
    case (i_op)
      MD_MULT: begin
        o_res_hi = w_prod_s[63:32];
        o_res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        o_res_hi = w_prod_u[63:32];
        o_res_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (i_rt != 32'd0) begin
          o_res_hi = w_rem_s;
          o_res_lo = w_quot_s;
        end
      end
      MD_DIVU: begin
        if (i_rt != 32'd0) begin
          o_res_hi = w_rem_mag;
          o_res_lo = w_quot_mag;
        end
      end
      default: begin
        o_res_hi = i_hi;
        o_res_lo = i_lo;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit_controller.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_controller
//  Description : Sequences the multi-cycle multiply/divide unit. A mult/div
//                result is computed at the start edge, held in pending
//                registers while busy counts down, and committed to HI/LO
//                on the last busy edge. mthi/mtlo write HI/LO directly.
//                Generates the ID stall for dependent MD instructions.
//  Ports       : clk    - system clock (rising edge)
//                reset  - synchronous, active-low
//                md     - md_unit_controller_if.slave (op request, busy,
//                         stall, hi, lo, read_data)
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit_controller
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input wire logic             clk,
  input wire logic             reset,
  md_unit_controller_if.slave  md
);

  localparam logic [3:0] c_mult_cycles = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cycles  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_start_busy_op;

  md_arith u_arith (
    .i_op     (md.op),
    .i_rs     (md.rs),
    .i_rt     (md.rt),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  assign w_start_busy_op = md.start && md_is_busy_op(md.op);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_busy_op) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_count   <= md_is_mult_op(md.op) ? c_mult_cycles : c_div_cycles;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
          end else if (md.start && (md.op == MD_MTHI)) begin
            r_hi <= md.rs;
          end else if (md.start && (md.op == MD_MTLO)) begin
            r_lo <= md.rs;
          end
        end
        RUN: begin
          // Any start seen here is ignored; stall keeps legal code out.
          if (r_count == 4'd1) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_busy  <= 1'b0;
            r_count <= 4'd0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_count <= 4'd0;
        end
      endcase
    end
  end

  assign md.busy  = r_busy;
  assign md.hi    = r_hi;
  assign md.lo    = r_lo;
  // The start term lets ID hold a dependent op in the same cycle EX issues
  // the mult/div, before busy has registered.
  assign md.stall = md.id_md_use && (r_busy || w_start_busy_op);

  always_comb begin
    md.read_data = 32'd0;
    if (md.op == MD_MFHI) begin
      md.read_data = r_hi;
    end else if (md.op == MD_MFLO) begin
      md.read_data = r_lo;
    end
  end

  a_no_start_while_run: assert property (
    @(posedge clk) disable iff (!reset) !(md.start && (r_state == RUN))
  );

endmodule
`default_nettype wire
